pipelined_cell_mesh: RTL and testbench



---
 rtl/pipelined_cell_mesh.sv | 139 +++++++++++++
 tb/tb_pipelined_cell_mesh.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cell_mesh.sv
// DEPTH-stage pipelined mesh of 2x2 routing cells with a fixed one-lane rotation between stages.
// Each accepted beat carries the config snapshot taken at acceptance through the pipe.
module pipelined_cell_mesh #(
   parameter int NUM_PAIRS = 6,
   parameter int DEPTH     = 4,
   parameter int DATA_W    = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              cfg_we,
   input  logic [2*NUM_PAIRS*DEPTH-1:0]      cfg_mode,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [2*NUM_PAIRS*DATA_W-1:0]     in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [2*NUM_PAIRS*DATA_W-1:0]     out_data,
   output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

   localparam int LANES   = 2 * NUM_PAIRS;
   localparam int LW      = LANES * DATA_W;
   localparam int PAIR_CW = 2 * NUM_PAIRS;
   localparam int CW      = PAIR_CW * DEPTH;
   localparam int OCC_W   = $clog2(DEPTH + 1);

   logic [CW-1:0]    cfg_reg;
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] up_valid;
   logic [DEPTH:0]   stage_ready;
   logic [OCC_W-1:0] occ_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_reg <= '0;
      end else if (cfg_we) begin
         cfg_reg <= cfg_mode;
      end
   end

   always_comb begin
      stage_ready[DEPTH] = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         stage_ready[k] = !valid_q[k] || stage_ready[k+1];
      end
   end

   always_comb begin
      up_valid[0] = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
         up_valid[k] = valid_q[k-1];
      end
   end

   // flush wins over acceptance: a beat offered in the flush cycle never lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (stage_ready[k]) begin
               valid_q[k] <= up_valid[k];
            end
         end
      end
   end

   always_comb begin
      occ_sum = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ_sum = occ_sum + OCC_W'(valid_q[k]);
      end
   end

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      // cfg_in holds the fields of this stage and all later ones; own field sits at the LSBs
      localparam int CIN_W = PAIR_CW * (DEPTH - s);
      logic [LW-1:0]    stage_in;
      logic [LW-1:0]    stage_out;
      logic [LW-1:0]    data_q;
      logic [CIN_W-1:0] cfg_in;
      logic             load;

      if (s == 0) begin : g_head
         assign stage_in = in_data;
         assign cfg_in   = cfg_reg;
      end else begin : g_link
         assign stage_in = {g_stage[s-1].data_q[LW-DATA_W-1:0], g_stage[s-1].data_q[LW-1 -: DATA_W]};
         assign cfg_in   = g_stage[s-1].g_carry.cfg_q;
      end

      for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_cell
         logic [1:0]        mode;
         logic [DATA_W-1:0] i1, i2, o1, o2;
         assign mode = cfg_in[2*p +: 2];
         assign i1   = stage_in[(2*p)*DATA_W +: DATA_W];
         assign i2   = stage_in[(2*p+1)*DATA_W +: DATA_W];
         always_comb begin
            o1 = i1;
            o2 = i2;
            case (mode)
               2'b00: begin o1 = i1; o2 = i2; end
               2'b01: begin o1 = i2; o2 = i1; end
               2'b10: begin o1 = i1; o2 = i1; end
               2'b11: begin o1 = i2; o2 = i2; end
               default: begin o1 = i1; o2 = i2; end
            endcase
         end
         assign stage_out[(2*p)*DATA_W +: DATA_W]   = o1;
         assign stage_out[(2*p+1)*DATA_W +: DATA_W] = o2;
      end

      assign load = stage_ready[s] && up_valid[s];

      always_ff @(posedge clk) begin
         if (load) begin
            data_q <= stage_out;
         end
      end

      if (s < DEPTH - 1) begin : g_carry
         logic [CIN_W-PAIR_CW-1:0] cfg_q;
         always_ff @(posedge clk) begin
            if (load) begin
               cfg_q <= cfg_in[CIN_W-1:PAIR_CW];
            end
         end
      end
   end

   assign in_ready  = stage_ready[0];
   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = g_stage[DEPTH-1].data_q;
   assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipelined_cell_mesh.sv
// Scoreboard bench for pipelined_cell_mesh: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_pipelined_cell_mesh;

   localparam int NP    = 6;
   localparam int DEPTH = 4;
   localparam int DW    = 8;
   localparam int LANES = 2 * NP;
   localparam int LW    = LANES * DW;
   localparam int CW    = 2 * NP * DEPTH;

   localparam logic [CW-1:0] CFG_PASS    = '0;
   localparam logic [CW-1:0] STAGE0_SWAP = 48'h0000_0000_0555;
   localparam logic [CW-1:0] ALL_SWAP    = 48'h5555_5555_5555;
   localparam logic [CW-1:0] CFG_MIX     = 48'h1BE4_936C_D227;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          cfg_we = 1'b0;
   logic [CW-1:0] cfg_mode = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [LW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [LW-1:0] out_data;
   logic [2:0]    occupancy;

   pipelined_cell_mesh #(.NUM_PAIRS(NP), .DEPTH(DEPTH), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int            tests = 0;
   int            fails = 0;
   logic [LW-1:0] exp_q[$];
   logic          prev_stall = 1'b0;
   logic [LW-1:0] held = '0;
   logic          done3 = 1'b0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired, required completion", name);
   endtask

   function automatic logic [LW-1:0] mk(input logic [7:0] base);
      logic [LW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*DW +: DW] = base + 8'(i);
      return r;
   endfunction

   // lane j of the output takes input lane (j-3) mod 12, optionally the stage-0 swap partner of it
   function automatic logic [LW-1:0] rot_exp(input bit sw);
      logic [LW-1:0] r;
      int src;
      for (int j = 0; j < LANES; j++) begin
         src = (j + 9) % LANES;
         if (sw) src = src ^ 1;
         r[j*DW +: DW] = 8'(src);
      end
      return r;
   endfunction

   function automatic logic [LW-1:0] model(input logic [LW-1:0] d, input logic [CW-1:0] c);
      logic [DW-1:0] ln [LANES];
      logic [DW-1:0] t  [LANES];
      logic [LW-1:0] r;
      logic [1:0]    m;
      for (int i = 0; i < LANES; i++) ln[i] = d[i*DW +: DW];
      for (int s = 0; s < DEPTH; s++) begin
         for (int p = 0; p < NP; p++) begin
            m = c[2*(s*NP+p) +: 2];
            case (m)
               2'b00: begin t[2*p] = ln[2*p];   t[2*p+1] = ln[2*p+1]; end
               2'b01: begin t[2*p] = ln[2*p+1]; t[2*p+1] = ln[2*p];   end
               2'b10: begin t[2*p] = ln[2*p];   t[2*p+1] = ln[2*p];   end
               default: begin t[2*p] = ln[2*p+1]; t[2*p+1] = ln[2*p+1]; end
            endcase
         end
         for (int l = 0; l < LANES; l++) begin
            if (s < DEPTH - 1) ln[(l+1) % LANES] = t[l];
            else ln[l] = t[l];
         end
      end
      for (int i = 0; i < LANES; i++) r[i*DW +: DW] = ln[i];
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         check("in_ready_rule", LW'(in_ready), LW'(!(occupancy == 3'd4 && !out_ready)));
         if (prev_stall && out_valid) check("stall_hold", out_data, held);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_beat");
            else check("beat", out_data, exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         held = out_data;
      end
   end

   task automatic send(input logic [LW-1:0] d, input logic [LW-1:0] e);
      int n = 0;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) fail_now("send_timeout");
      else exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         fail_now(name);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_load(input logic [CW-1:0] v);
      cfg_mode = v;
      cfg_we   = 1'b1;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   initial begin
      #2;
      check("reset_out_valid", LW'(out_valid), LW'(0));
      check("reset_occupancy", LW'(occupancy), LW'(0));
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_in_ready", LW'(in_ready), LW'(1));

      // all pass, lane i = i, plus latency
      send(mk(8'd0), rot_exp(1'b0));
      check("lat_edge_t", LW'(out_valid), LW'(0));
      repeat (2) begin
         @(posedge clk);
         #1;
         check("lat_early", LW'(out_valid), LW'(0));
      end
      @(posedge clk);
      #1;
      check("lat_edge_t3", LW'(out_valid), LW'(1));
      check("pass_lane0", LW'(out_data[0 +: DW]), LW'(9));
      check("pass_lane3", LW'(out_data[3*DW +: DW]), LW'(0));
      wait_drain("drain_pass");

      // stage 0 swap, rest pass
      cfg_load(STAGE0_SWAP);
      send(mk(8'd0), rot_exp(1'b1));
      wait_drain("drain_swap0");

      // 20 back-to-back beats under random backpressure
      cfg_load(CFG_MIX);
      done3 = 1'b0;
      fork
         begin : g_src
            for (int k = 0; k < 20; k++) send(mk(8'(16*k + 3)), model(mk(8'(16*k + 3)), CFG_MIX));
            done3 = 1'b1;
         end
         begin : g_sink
            for (int c = 0; c < 600 && !(done3 && exp_q.size() == 0); c++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_drain("drain_stream");

      // config snapshot: A with cfg_we in its acceptance cycle, B the next cycle
      cfg_load(CFG_PASS);
      cfg_mode = ALL_SWAP;
      cfg_we   = 1'b1;
      send(mk(8'd40), model(mk(8'd40), CFG_PASS));
      cfg_we = 1'b0;
      send(mk(8'd80), model(mk(8'd80), ALL_SWAP));
      wait_drain("drain_snapshot");

      // fill, then flush with a beat offered in the flush cycle
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(mk(8'(100 + k)), model(mk(8'(100 + k)), ALL_SWAP));
      check("full_occupancy", LW'(occupancy), LW'(4));
      check("full_in_ready", LW'(in_ready), LW'(0));
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = mk(8'd200);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      check("flush_occupancy", LW'(occupancy), LW'(0));
      check("flush_out_valid", LW'(out_valid), LW'(0));
      check("flush_in_ready", LW'(in_ready), LW'(1));
      out_ready = 1'b1;
      send(mk(8'd7), model(mk(8'd7), ALL_SWAP));
      wait_drain("drain_flush");

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(mk(8'(60 + k)), model(mk(8'(60 + k)), ALL_SWAP));
      #3;
      check("pre_reset_out_valid", LW'(out_valid), LW'(1));
      rst_n = 1'b0;
      #1;
      check("async_reset_out_valid", LW'(out_valid), LW'(0));
      check("async_reset_occupancy", LW'(occupancy), LW'(0));
      exp_q.delete();
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_occupancy", LW'(occupancy), LW'(0));
      out_ready = 1'b1;
      send(mk(8'd50), model(mk(8'd50), CFG_PASS));
      wait_drain("drain_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
